// File: rtl/four_adder_seq.sv
// Wide add/subtract sequencer: one 4-bit adder slice reused per nibble, LSB first,
// with the inter-nibble carry held in a register.

module four_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module four_adder_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow
);
  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      a_nib_c, b_nib_c, sum_c;
  logic            carry_c;

  // Select the current nibble of the captured operands; B is inverted for subtract
  always_comb begin
    a_nib_c = 4'h0;
    b_nib_c = 4'h0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IW'(i)) begin
        a_nib_c = a_q[4*i +: 4];
        b_nib_c = b_q[4*i +: 4] ^ {4{sub_q}};
      end
    end
  end

  four_adder u_slice (
    .a    (a_nib_c),
    .b    (b_nib_c),
    .cin  (carry_q),
    .sum  (sum_c),
    .cout (carry_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          sub_d    = sub;
          carry_d  = sub ? 1'b1 : cin;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = sum_c;
        end
        carry_d = carry_c;
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NIBBLES - 1)) begin
          // Signed overflow: operands agree in sign but the sum's sign differs
          cout_d  = carry_c;
          ovf_d   = (a_nib_c[3] == b_nib_c[3]) && (sum_c[3] != a_nib_c[3]);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
